if_pc_predict: RTL and testbench

- IF-stage program-counter unit with a direct-mapped branch target buffer (BTB) and 2-bit saturating-counter branch history table (BHT).
- Sits directly upstream of the hazard unit:
  - Produces the fetch PC and the per-instruction prediction (carried down the pipe into the hazard unit's prediction input).
  - Consumes the hazard unit's redirect/stall/interrupt outcomes to select the next PC and train the predictor.

---
 rtl/if_pc_predict.sv | 100 ++++++++++
 tb/tb_if_pc_predict.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_pc_predict.sv
// IF-stage PC generator with a direct-mapped BTB and a 2-bit saturating-counter BHT.
// Latency: the lookup is combinational from pc_o. The next PC and table training take effect on the next rising edge.
// Backpressure: stall_i holds the PC. Any interrupt, jump-register or mispredict redirect overrides it.
module if_pc_predict #(
  parameter int          IDX_W      = 4,
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] INT_VECTOR = 16'h0005
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall_i,
  input  logic        isintzero_i,
  input  logic        jr_i,
  input  logic [15:0] jr_target_i,
  input  logic        prewrong_i,
  input  logic        precorrc_i,
  input  logic [15:0] br_pc_i,
  input  logic        br_taken_i,
  input  logic [15:0] br_target_i,
  output logic [15:0] pc_o,
  output logic [15:0] pc_plus1_o,
  output logic        prediction_o,
  output logic [15:0] pred_target_o
);
  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 16 - IDX_W;

  logic [15:0]      pc_q;
  logic [DEPTH-1:0] vld_q;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [15:0]      tgt_q [DEPTH];
  logic [1:0]       ctr_q [DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_hit;
  logic             wr_hit;
  logic             train;
  logic [1:0]       ctr_upd;
  logic [15:0]      pc_next;

  // Lookup for the current fetch PC. The tables are read before any same-edge training.
  assign rd_idx        = pc_q[IDX_W-1:0];
  assign rd_hit        = vld_q[rd_idx] && (tag_q[rd_idx] == pc_q[15:IDX_W]);
  assign pc_o          = pc_q;
  assign pc_plus1_o    = pc_q + 16'd1;
  assign prediction_o  = rd_hit && ctr_q[rd_idx][1];
  assign pred_target_o = prediction_o ? tgt_q[rd_idx] : pc_plus1_o;

  // Training port. It is addressed by the resolving branch and suppressed when an interrupt is taken.
  // If prewrong and precorrc are asserted together, the update is the same as for prewrong.
  assign wr_idx = br_pc_i[IDX_W-1:0];
  assign wr_hit = vld_q[wr_idx] && (tag_q[wr_idx] == br_pc_i[15:IDX_W]);
  assign train  = (prewrong_i || precorrc_i) && !isintzero_i;

  // Next-PC select: interrupt > jump-register > mispredict > stall > predicted path.
  always_comb begin
    pc_next = pred_target_o;
    if (isintzero_i)     pc_next = INT_VECTOR;
    else if (jr_i)       pc_next = jr_target_i;
    else if (prewrong_i) pc_next = br_taken_i ? br_target_i : (br_pc_i + 16'd1);
    else if (stall_i)    pc_next = pc_q;
  end

  // Counter update. A miss allocates a weak state in the resolved direction; a hit saturates at 00 and 11.
  always_comb begin
    ctr_upd = ctr_q[wr_idx];
    if (!wr_hit) begin
      ctr_upd = br_taken_i ? 2'b10 : 2'b01;
    end else if (br_taken_i) begin
      if (ctr_q[wr_idx] != 2'b11) ctr_upd = ctr_q[wr_idx] + 2'd1;
    end else begin
      if (ctr_q[wr_idx] != 2'b00) ctr_upd = ctr_q[wr_idx] - 2'd1;
    end
  end

  // Fetch PC register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) pc_q <= RESET_PC;
    else      pc_q <= pc_next;
  end

  // BTB/BHT storage. A miss replaces the whole entry. A hit keeps the old target on not-taken.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else if (train) begin
      vld_q[wr_idx] <= 1'b1;
      tag_q[wr_idx] <= br_pc_i[15:IDX_W];
      ctr_q[wr_idx] <= ctr_upd;
      if (br_taken_i || !wr_hit) tgt_q[wr_idx] <= br_target_i;
    end
  end

endmodule

// File: tb/tb_if_pc_predict.sv
// Directed bench for if_pc_predict.
// Stimulus pushes cycle-stamped expectations into a queue, and a monitor compares them against the DUT outputs.
// Samples are taken on the falling edge, or on demand for the asynchronous-reset case.
module tb_if_pc_predict;
  logic        CLK = 1'b0;
  logic        RST;
  logic        stall_i, isintzero_i, jr_i, prewrong_i, precorrc_i, br_taken_i;
  logic [15:0] jr_target_i, br_pc_i, br_target_i;
  logic [15:0] pc_o, pc_plus1_o, pred_target_o;
  logic        prediction_o;

  typedef struct {
    int          cyc;
    logic [15:0] pc;
    logic        pred;
    logic [15:0] tgt;
  } exp_t;

  exp_t  eq[$];
  string nq[$];
  int    cyc   = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  event  smp_ev;

  if_pc_predict dut (
    .CLK(CLK), .RST(RST), .stall_i(stall_i), .isintzero_i(isintzero_i),
    .jr_i(jr_i), .jr_target_i(jr_target_i), .prewrong_i(prewrong_i),
    .precorrc_i(precorrc_i), .br_pc_i(br_pc_i), .br_taken_i(br_taken_i),
    .br_target_i(br_target_i), .pc_o(pc_o), .pc_plus1_o(pc_plus1_o),
    .prediction_o(prediction_o), .pred_target_o(pred_target_o)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    stall_i = 0; isintzero_i = 0; jr_i = 0; prewrong_i = 0; precorrc_i = 0;
    br_taken_i = 0; jr_target_i = '0; br_pc_i = '0; br_target_i = '0;
  endtask

  task automatic push(input string n, input int c, input logic [15:0] pc,
                      input logic pred, input logic [15:0] tgt);
    exp_t e;
    e.cyc = c; e.pc = pc; e.pred = pred; e.tgt = tgt;
    eq.push_back(e);
    nq.push_back(n);
  endtask

  // Check the outputs as they stand now, before the next rising edge.
  task automatic exp_now(input string n, input logic [15:0] pc, input logic pred, input logic [15:0] tgt);
    push(n, cyc, pc, pred, tgt);
  endtask

  // Check the outputs after the next rising edge.
  task automatic exp_next(input string n, input logic [15:0] pc, input logic pred, input logic [15:0] tgt);
    push(n, cyc + 1, pc, pred, tgt);
  endtask

  task automatic go_to(input logic [15:0] a);
    jr_i = 1; jr_target_i = a;
    tick();
    clr();
  endtask

  task automatic set_br(input logic wrong, input logic corr, input logic [15:0] bpc,
                        input logic tk, input logic [15:0] btgt);
    prewrong_i = wrong; precorrc_i = corr; br_pc_i = bpc; br_taken_i = tk; br_target_i = btgt;
  endtask

  // Monitor: compare every expectation whose stamp has come due.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge CLK or smp_ev);
      while (eq.size() > 0 && eq[0].cyc <= cyc) begin
        e = eq.pop_front();
        n = nq.pop_front();
        n_cmp++;
        if (e.cyc < cyc) begin
          n_bad++;
          $display("FAIL %s: sample missed (stamp %0d, now %0d)", n, e.cyc, cyc);
        end else if (pc_o !== e.pc || prediction_o !== e.pred || pred_target_o !== e.tgt ||
                     pc_plus1_o !== e.pc + 16'd1) begin
          n_bad++;
          $display("FAIL %s: got pc=%h p1=%h pred=%b tgt=%h, want pc=%h p1=%h pred=%b tgt=%h",
                   n, pc_o, pc_plus1_o, prediction_o, pred_target_o, e.pc, e.pc + 16'd1, e.pred, e.tgt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d expectations pending", eq.size());
    $fatal(1);
  end

  initial begin
    clr();
    RST = 0;
    repeat (2) tick();
    exp_now("reset", 16'h0000, 0, 16'h0001);
    RST = 1;
    exp_next("seq1", 16'h0001, 0, 16'h0002); tick();
    exp_next("seq2", 16'h0002, 0, 16'h0003); tick();

    // Three taken updates on 0x0013: the first allocates at 10, then 11, then 11 stays saturated.
    set_br(0, 1, 16'h0013, 1, 16'h0040);
    exp_next("train1", 16'h0003, 0, 16'h0004); tick();
    exp_next("train2", 16'h0004, 0, 16'h0005); tick();
    exp_next("train3", 16'h0005, 0, 16'h0006); tick();
    clr();
    go_to(16'h0013);
    exp_now("hit13", 16'h0013, 1, 16'h0040);
    exp_next("follow", 16'h0040, 0, 16'h0041); tick();

    // One not-taken update: 11 -> 10, so the entry still predicts taken.
    set_br(0, 1, 16'h0013, 0, 16'h0040);
    exp_next("nt1", 16'h0041, 0, 16'h0042); tick();
    clr();
    go_to(16'h0013);
    exp_now("nt1_pred", 16'h0013, 1, 16'h0040);
    // The same-cycle lookup still follows the pre-update entry; the counter then goes 10 -> 01 -> 00 -> 00.
    set_br(0, 1, 16'h0013, 0, 16'h0040);
    exp_next("nt2_preupd", 16'h0040, 0, 16'h0041); tick();
    exp_next("nt3", 16'h0041, 0, 16'h0042); tick();
    exp_next("nt4", 16'h0042, 0, 16'h0043); tick();
    clr();
    go_to(16'h0013);
    exp_now("nt_sat", 16'h0013, 0, 16'h0014);

    // Mispredict redirects.
    go_to(16'h0030);
    set_br(1, 0, 16'h0021, 0, 16'h0050);
    exp_next("mp_nt", 16'h0022, 0, 16'h0023); tick();
    clr();
    go_to(16'h0030);
    set_br(1, 0, 16'h0021, 1, 16'h0050);
    exp_next("mp_t", 16'h0050, 0, 16'h0051); tick();
    clr();
    go_to(16'h0021);
    exp_now("mp_trained", 16'h0021, 1, 16'h0050);

    // Priority: the interrupt wins over jr and stall, and blocks training.
    isintzero_i = 1; jr_i = 1; jr_target_i = 16'h0100; stall_i = 1;
    set_br(0, 1, 16'h0060, 1, 16'h0077);
    exp_next("int_pri", 16'h0005, 0, 16'h0006); tick();
    clr();
    go_to(16'h0060);
    exp_now("int_nowr", 16'h0060, 0, 16'h0061);
    jr_i = 1; jr_target_i = 16'h0100; stall_i = 1;
    set_br(1, 0, 16'h0021, 0, 16'h0050);
    exp_next("jr_pri", 16'h0100, 0, 16'h0101); tick();
    clr();
    stall_i = 1;
    set_br(1, 0, 16'h0021, 1, 16'h0050);
    exp_next("pw_pri", 16'h0050, 0, 16'h0051); tick();
    clr();

    // Stall holds the PC.
    go_to(16'h0007);
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      exp_next("stall", 16'h0007, 0, 16'h0008); tick();
    end
    clr();
    exp_next("unstall", 16'h0008, 0, 16'h0009); tick();

    // Alias: 0x0003 replaces the 0x0013 entry at index 3.
    set_br(0, 1, 16'h0003, 1, 16'h0099);
    exp_next("al_tr", 16'h0009, 0, 16'h000A); tick();
    clr();
    go_to(16'h0013);
    exp_now("alias", 16'h0013, 0, 16'h0014);
    go_to(16'h0003);
    exp_now("alias_own", 16'h0003, 1, 16'h0099);

    // Wrap of pc+1 and of br_pc+1.
    go_to(16'hFFFF);
    exp_now("wrap_cur", 16'hFFFF, 0, 16'h0000);
    exp_next("wrap", 16'h0000, 0, 16'h0001); tick();
    go_to(16'h0040);
    set_br(1, 0, 16'hFFFF, 0, 16'h1234);
    exp_next("br_wrap", 16'h0000, 0, 16'h0001); tick();
    clr();

    // Asynchronous reset between edges.
    go_to(16'h0042);
    exp_now("pre_rst", 16'h0042, 0, 16'h0043);
    @(negedge CLK);
    #2;
    RST = 0;
    #1;
    exp_now("async_rst", 16'h0000, 0, 16'h0001);
    ->smp_ev;
    tick();
    RST = 1;
    exp_now("rst_hold", 16'h0000, 0, 16'h0001);
    exp_next("rst_rel", 16'h0001, 0, 16'h0002); tick();
    go_to(16'h0003);
    exp_now("rst_clr3", 16'h0003, 0, 16'h0004);
    go_to(16'h0021);
    exp_now("rst_clr21", 16'h0021, 0, 16'h0022);
    repeat (2) tick();

    while (eq.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never sampled (stamp %0d, now %0d)", nq[0], eq[0].cyc, cyc);
      void'(eq.pop_front());
      void'(nq.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
